// File: rtl/led_pwm_periph.sv
// Memory-mapped four-channel 8-bit PWM peripheral with prescaler and period-synchronous duty shadowing.
// Duty changes reach the outputs only at the period wrap or on an explicit SYNC, so the outputs never glitch.
module led_pwm_periph #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    output logic [31:0] bus_rdata,
    output logic        pwm_led,
    output logic        pwm_red,
    output logic        pwm_green,
    output logic        pwm_blue
);

    localparam logic [2:0] OFF_PRESC = 3'd4;
    localparam logic [2:0] OFF_CTRL  = 3'd5;
    localparam logic [2:0] OFF_CNT   = 3'd6;

    logic [7:0]         duty   [4];
    logic [7:0]         shadow [4];
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic [3:0]         en;
    logic [7:0]         cnt;
    logic [3:0]         pwm_p1;

    logic        hit;
    logic [2:0]  off;
    logic        wr;
    logic        presc_wr;
    logic        sync;
    logic        tick;
    logic [31:0] rd_next;

    assign hit      = (bus_addr[31:5] == BASE_ADDR[31:5]);
    assign off      = bus_addr[4:2];
    assign wr       = bus_we && hit;
    assign presc_wr = wr && (off == OFF_PRESC);
    assign sync     = wr && (off == OFF_CTRL) && bus_wdata[4];
    // A prescaler reload write restarts the prescale interval and swallows this cycle's tick.
    assign tick     = !presc_wr && (pcnt == presc);

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:PRESC_W]};

    always_comb begin
        rd_next = '0;
        if (hit) begin
            case (off)
                3'd0, 3'd1, 3'd2, 3'd3: rd_next[7:0] = duty[off[1:0]];
                OFF_PRESC:              rd_next[PRESC_W-1:0] = presc;
                OFF_CTRL:               rd_next[3:0] = en;
                OFF_CNT:                rd_next[7:0] = cnt;
                default:                rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            pcnt      <= '0;
            en        <= '0;
            cnt       <= '0;
            pwm_p1    <= '0;
            bus_rdata <= '0;
            for (int i = 0; i < 4; i++) begin
                duty[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            bus_rdata <= rd_next;

            // stage p0 -> p1: compare against the shadowed duty and register the outputs
            for (int i = 0; i < 4; i++) begin
                pwm_p1[i] <= en[i] && (cnt < shadow[i]);
            end

            if (wr) begin
                case (off)
                    3'd0, 3'd1, 3'd2, 3'd3: duty[off[1:0]] <= bus_wdata[7:0];
                    OFF_PRESC:              presc <= bus_wdata[PRESC_W-1:0];
                    OFF_CTRL:               en <= bus_wdata[3:0];
                    default:                ;
                endcase
            end

            // SYNC overrides any coincident tick or wrap; shadows load from pre-write duty at wrap.
            if (sync) begin
                cnt  <= '0;
                pcnt <= '0;
                for (int i = 0; i < 4; i++) begin
                    shadow[i] <= duty[i];
                end
            end else if (tick) begin
                pcnt <= '0;
                cnt  <= cnt + 8'd1;
                if (cnt == 8'hFF) begin
                    for (int i = 0; i < 4; i++) begin
                        shadow[i] <= duty[i];
                    end
                end
            end else if (presc_wr) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    assign pwm_led   = pwm_p1[0];
    assign pwm_red   = pwm_p1[1];
    assign pwm_green = pwm_p1[2];
    assign pwm_blue  = pwm_p1[3];

endmodule
